// File: rtl/mult_div_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit that owns HI/LO.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Exception vector the control unit jumps to on a divide by zero.
    localparam logic [7:0] DIV_ZERO_ADDR = 8'd255;

endpackage

// File: rtl/mult_div_unit_cond_negate.sv
// Conditional two's-complement negator: dout = neg ? -din : din.
module cond_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning HI and LO.
// One step per cycle for WIDTH cycles, then a sign-fix cycle and a done pulse.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd_b;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes; unsigned operations never negate.
    assign a_neg = op_signed & a[WIDTH-1];
    assign b_neg = op_signed & b[WIDTH-1];

    cond_negate #(.WIDTH(WIDTH)) u_neg_a (.neg(a_neg), .din(a), .dout(a_mag));
    cond_negate #(.WIDTH(WIDTH)) u_neg_b (.neg(b_neg), .din(b), .dout(b_mag));

    // Result sign correction applied in FIX.
    cond_negate #(.WIDTH(2*WIDTH)) u_neg_prod (.neg(neg_q), .din({acc_hi, acc_lo}), .dout(prod_fix));
    cond_negate #(.WIDTH(WIDTH))   u_neg_quo  (.neg(neg_q), .din(acc_lo),           .dout(quo_fix));
    cond_negate #(.WIDTH(WIDTH))   u_neg_rem  (.neg(neg_r), .din(acc_hi),           .dout(rem_fix));

    // One iteration: acc_lo holds multiplier / dividend bits, acc_hi the partial product / remainder.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_b};
        step_hi   = mul_sum[WIDTH:1];
        step_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd_b   <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (op_div == OP_DIV && b == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            acc_hi <= '0;
                            acc_lo <= a_mag;
                            opnd_b <= b_mag;
                            is_div <= op_div;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= op_div & a_neg;
                            cnt    <= CNT_W'(WIDTH);
                            state  <= RUN;
                        end
                    end else begin
                        if (hi_wr) hi_out <= a;
                        if (lo_wr) lo_out <= a;
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
                FIX: begin
                    hi_out <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                    lo_out <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit at WIDTH=32 and WIDTH=8.
module tb_mult_div_unit;

    typedef struct {
        bit          sel;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start32, op_div32, op_signed32, hi_wr32, lo_wr32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        busy32, done32, dz32;
    logic        start8, op_div8, op_signed8, hi_wr8, lo_wr8;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy8, done8, dz8;

    int vectors = 0;
    int errors  = 0;
    exp_t exp_q[$];

    mult_div_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .start(start32), .op_div(op_div32), .op_signed(op_signed32),
        .a(a32), .b(b32), .hi_wr(hi_wr32), .lo_wr(lo_wr32), .hi_out(hi32), .lo_out(lo32),
        .busy(busy32), .done(done32), .div_zero(dz32)
    );

    mult_div_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .op_div(op_div8), .op_signed(op_signed8),
        .a(a8), .b(b8), .hi_wr(hi_wr8), .lo_wr(lo_wr8), .hi_out(hi8), .lo_out(lo8),
        .busy(busy8), .done(done8), .div_zero(dz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result {hi, lo} computed with wide integer arithmetic.
    function automatic logic [63:0] model(input bit dv, input bit sg, input logic [31:0] aa,
                                          input logic [31:0] bb, input int w);
        longint mask, sa, sb, p, q, r;
        mask = (longint'(1) <<< w) - 1;
        sa = longint'(aa) & mask;
        sb = longint'(bb) & mask;
        if (sg && aa[w-1]) sa = sa - (longint'(1) <<< w);
        if (sg && bb[w-1]) sb = sb - (longint'(1) <<< w);
        if (dv) begin
            q = sa / sb;
            r = sa % sb;
            return {32'(r & mask), 32'(q & mask)};
        end
        p = sa * sb;
        return {32'((p >>> w) & mask), 32'(p & mask)};
    endfunction

    task automatic drive(input bit sel, input bit st, input bit dv, input bit sg,
                         input logic [31:0] aa, input logic [31:0] bb);
        if (sel) begin
            start8 = st; op_div8 = dv; op_signed8 = sg; a8 = aa[7:0]; b8 = bb[7:0];
        end else begin
            start32 = st; op_div32 = dv; op_signed32 = sg; a32 = aa; b32 = bb;
        end
    endtask

    // Push the expectation, issue start, and compare when done appears.
    task automatic issue(input bit sel, input bit dv, input bit sg, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input int elat);
        int   cycles;
        exp_t e;
        exp_q.push_back('{sel: sel, hi: ehi, lo: elo, dz: edz, lat: elat});
        @(negedge clk);
        drive(sel, 1'b1, dv, sg, aa, bb);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycles = 1;
        while (!(sel ? done8 : done32) && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        e = exp_q.pop_front();
        check("done_seen", 64'(sel ? done8 : done32), 64'd1);
        check("latency",   64'(cycles), 64'(e.lat));
        check("hi",        64'(sel ? {24'h0, hi8} : hi32), 64'(e.hi));
        check("lo",        64'(sel ? {24'h0, lo8} : lo32), 64'(e.lo));
        check("div_zero",  64'(sel ? dz8 : dz32), 64'(e.dz));
        check("busy_done", 64'(sel ? busy8 : busy32), 64'd1);
        @(negedge clk);
        check("done_pulse", 64'(sel ? done8 : done32), 64'd0);
        check("busy_idle",  64'(sel ? busy8 : busy32), 64'd0);
    endtask

    task automatic issue_model(input bit dv, input bit sg, input logic [31:0] aa, input logic [31:0] bb);
        logic [63:0] r;
        r = model(dv, sg, aa, bb, 32);
        issue(1'b0, dv, sg, aa, bb, r[63:32], r[31:0], 1'b0, 34);
    endtask

    initial begin
        int pulses;
        logic [31:0] ra, rb;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        hi_wr32 = 1'b0; lo_wr32 = 1'b0; hi_wr8 = 1'b0; lo_wr8 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hi",   64'(hi32), 64'd0);
        check("rst_lo",   64'(lo32), 64'd0);
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_done", 64'({done32, dz32}), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        issue(1'b0, 1'b1 ^ 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
        issue(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
        issue(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        issue(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34);
        issue_model(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
        issue_model(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (rb == 32'h0) rb = 32'd3;
            issue_model(i[1], i[0], ra, rb);
        end

        // Both writes together load the same value.
        hi_wr32 = 1'b1; lo_wr32 = 1'b1; a32 = 32'h0000_5A5A;
        @(negedge clk);
        check("mthi_mtlo_hi", 64'(hi32), 64'h5A5A);
        check("mthi_mtlo_lo", 64'(lo32), 64'h5A5A);
        hi_wr32 = 1'b1; lo_wr32 = 1'b0; a32 = 32'h12;
        @(negedge clk);
        hi_wr32 = 1'b0; lo_wr32 = 1'b1; a32 = 32'h34;
        @(negedge clk);
        lo_wr32 = 1'b0; a32 = 32'h0;
        check("preload_hi", 64'(hi32), 64'h12);
        check("preload_lo", 64'(lo32), 64'h34);
        issue(1'b0, 1'b1, 1'b1, 32'd99, 32'h0, 32'h12, 32'h34, 1'b1, 1);

        // Reset in the middle of RUN aborts with no completion pulse.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_hi",   64'(hi32), 64'd0);
        check("abort_lo",   64'(lo32), 64'd0);
        check("abort_busy", 64'(busy32), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);

        issue(1'b1, 1'b0, 1'b0, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0, 10);
        begin
            logic [63:0] r8;
            r8 = model(1'b1, 1'b1, 32'h81, 32'h07, 8);
            issue(1'b1, 1'b1, 1'b1, 32'h81, 32'h07, r8[63:32], r8[31:0], 1'b0, 10);
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
